pipe_skid_reg: RTL and testbench

Parametrised pipeline stage register: the successor to the fixed per-stage IF/ID, ID/EX, EX/MEM and MEM/WB structs. It carries an opaque packed payload of any width between pipeline stages using a valid/ready handshake, with synchronous flush and a saturating stall-cycle counter. With the skid option compiled in, it registers backpressure so that `in_ready` has no combinational path from `out_ready`, while keeping full throughput. Every core stage boundary instantiates one, with `WIDTH` set from the `$bits()` of the stage's packed struct.

---
 rtl/pipe_skid_reg.sv | 192 +++++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Generic pipeline stage register carrying an opaque WIDTH-bit payload between
// core stages over a valid/ready handshake. Provides a synchronous flush and a
// saturating counter of stalled output cycles.
//
// Build option (macro PIPE_SKID_EN):
//   defined   - two-entry skid build (main + skid register). in_ready comes
//               straight from a flop, so there is no combinational path from
//               out_ready to in_ready, and full throughput is kept.
//   undefined - single register (EMPTY/ONE only); in_ready is the
//               combinational term !out_valid || out_ready.
//
// Parameters:
//   WIDTH  payload width in bits (>= 1)
//   CNT_W  stall counter width in bits (>= 1)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous flush, drops held and incoming beats
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat
//   in_data    upstream payload
//   out_valid  beat available downstream
//   out_ready  downstream accepts
//   out_data   downstream payload (always the main register)
//   clr_cnt    synchronous clear of stall_cnt
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;

`ifdef PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             in_ready_q;
  logic             load_skid;
  logic             main_from_skid;
`endif

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign out_data = main_q;

`ifdef PIPE_SKID_EN
  assign in_ready = in_ready_q;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  // State register; reset clears occupancy immediately so out_valid drops
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition and empties the stage.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) state_d = ONE;
        end
        ONE: begin
`ifdef PIPE_SKID_EN
          if (in_xfer && !out_xfer) begin
            state_d = TWO;
          end else if (!in_xfer && out_xfer) begin
            state_d = EMPTY;
          end
`else
          if (!in_xfer && out_xfer) state_d = EMPTY;
`endif
        end
        TWO: begin
          if (out_xfer) state_d = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output decode: occupancy flag and register load strobes. A beat taken in
  // a flush cycle is never loaded.
  always_comb begin
    out_valid = (state_q != EMPTY);
    load_main = 1'b0;
`ifdef PIPE_SKID_EN
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (!flush) begin
      case (state_q)
        EMPTY: load_main = in_xfer;
        ONE: begin
          load_main = in_xfer && out_xfer;
`ifdef PIPE_SKID_EN
          load_skid = in_xfer && !out_xfer;
`endif
        end
`ifdef PIPE_SKID_EN
        TWO: main_from_skid = out_xfer;
`endif
        default: load_main = 1'b0;
      endcase
    end
  end

  // Payload registers; contents survive a flush, only occupancy is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
    end else if (load_main) begin
      main_q <= in_data;
`ifdef PIPE_SKID_EN
    end else if (main_from_skid) begin
      main_q <= skid_q;
`endif
    end
  end

`ifdef PIPE_SKID_EN
  // Skid entry catches the one beat that slips in while backpressure is
  // still being registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_data;
    end
  end

  // Registered ready: low exactly while the stage will hold two beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != TWO);
    end
  end
`endif

  // Stall counter; clear wins over increment, saturates instead of wrapping,
  // and is deliberately untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Self-checking bench for pipe_skid_reg. Accepted input beats are pushed to an
// expected-data queue; each output handshake pops and compares against it.
// A second instance with CNT_W=3 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       clr_cnt;
  logic [15:0] stall_cnt;

  logic       sat_flush;
  logic       sat_in_valid;
  logic       sat_in_ready;
  logic [7:0] sat_in_data;
  logic       sat_out_valid;
  logic       sat_out_ready;
  logic [7:0] sat_out_data;
  logic       sat_clr_cnt;
  logic [2:0] sat_stall_cnt;

  logic [7:0] exp_q[$];
  logic [7:0] exp_beat;
  logic       obs_out_valid;
  logic [7:0] obs_out_data;
  logic       obs_out_xfer;
  logic       obs_in_xfer;

  int n_cmp;
  int n_fail;

  pipe_skid_reg #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clr_cnt(clr_cnt), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.WIDTH(8), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(sat_flush),
    .in_valid(sat_in_valid), .in_ready(sat_in_ready), .in_data(sat_in_data),
    .out_valid(sat_out_valid), .out_ready(sat_out_ready), .out_data(sat_out_data),
    .clr_cnt(sat_clr_cnt), .stall_cnt(sat_stall_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so a wedged DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one cycle: observe handshakes on the falling edge, record accepted
  // input beats, then return 1 time unit after the next rising edge.
  task automatic step();
    @(negedge clk);
    obs_out_valid = out_valid;
    obs_out_data  = out_data;
    obs_out_xfer  = out_valid && out_ready && !flush;
    obs_in_xfer   = in_valid && in_ready && !flush;
    if (flush) exp_q.delete();
    else if (obs_in_xfer) exp_q.push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (out_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 00", out_data); end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
        n_fail++;
        $display("[TB] FAIL stream_latency: got v=%b d=%h expected v=1 d=%h", out_valid, out_data, 8'(i));
      end
      if (obs_out_xfer) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL stream_order: got %h expected nothing", obs_out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL stream_order: got %h expected %h", obs_out_data, exp_beat); end
        end
      end
    end
    in_valid = 1'b0;
    step();
    if (obs_out_xfer) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL stream_order: got %h expected nothing", obs_out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL stream_order: got %h expected %h", obs_out_data, exp_beat); end
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL stream_drain: got v=%b left=%0d expected v=0 left=0", out_valid, exp_q.size());
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL stream_stall_cnt: got %0d expected 0", stall_cnt); end
  endtask

  task automatic test_skid();
    int out_cnt;
    out_cnt   = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h0A;
    step();
`ifdef PIPE_SKID_EN
    out_ready = 1'b0;
    in_data   = 8'h0B;
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h0A) begin
      n_fail++; $display("[TB] FAIL skid_two: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=0a", in_ready, out_valid, out_data);
    end
    in_data = 8'h0C;
    step();
    n_cmp++;
    if (in_ready !== 1'b0 || out_data !== 8'h0A || obs_in_xfer) begin
      n_fail++; $display("[TB] FAIL skid_hold: got rdy=%b d=%h took=%b expected rdy=0 d=0a took=0", in_ready, out_data, obs_in_xfer);
    end
    out_ready = 1'b1;
    step();
    if (obs_out_xfer) out_cnt++;
    if (obs_out_xfer) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL skid_order: got %h expected nothing", obs_out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL skid_order: got %h expected %h", obs_out_data, exp_beat); end
      end
    end
    n_cmp++;
    if (in_ready !== 1'b1 || out_data !== 8'h0B) begin
      n_fail++; $display("[TB] FAIL skid_release: got rdy=%b d=%h expected rdy=1 d=0b", in_ready, out_data);
    end
`else
    out_ready = 1'b0;
    in_data   = 8'h0B;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL comb_ready_low: got %b expected 0", in_ready); end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL comb_ready_high: got %b expected 1", in_ready); end
`endif
    for (int c = 0; c < 20; c++) begin
      step();
      if (obs_in_xfer) in_valid = 1'b0;
      if (obs_out_xfer) begin
        out_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL skid_order: got %h expected nothing", obs_out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL skid_order: got %h expected %h", obs_out_data, exp_beat); end
        end
      end
      if (!in_valid && !out_valid && exp_q.size() == 0) break;
    end
    in_valid = 1'b0;
    n_cmp++;
`ifdef PIPE_SKID_EN
    if (out_cnt != 3 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL skid_count: got %0d beats v=%b expected 3 beats v=0", out_cnt, out_valid);
    end
`else
    if (out_cnt != 2 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL skid_count: got %0d beats v=%b expected 2 beats v=0", out_cnt, out_valid);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int sent;
    int recv;
    sent = 0;
    recv = 0;
    for (int c = 0; c < 300 && sent < 12; c++) begin
      in_valid  = 1'b1;
      in_data   = 8'h40 + 8'(sent);
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (obs_in_xfer) sent++;
      if (obs_out_xfer) begin
        recv++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_order: got %h expected nothing", obs_out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL b2b_order: got %h expected %h", obs_out_data, exp_beat); end
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      if (obs_out_xfer) begin
        recv++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("[TB] FAIL b2b_order: got %h expected nothing", obs_out_data);
        end else begin
          exp_beat = exp_q.pop_front();
          if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL b2b_order: got %h expected %h", obs_out_data, exp_beat); end
        end
      end
    end
    n_cmp++;
    if (sent != 12 || recv != 12 || exp_q.size() != 0) begin
      n_fail++; $display("[TB] FAIL b2b_count: got sent=%0d recv=%0d expected 12/12", sent, recv);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    clr_cnt   = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h55;
    step();
    clr_cnt  = 1'b0;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) step();
    n_cmp++;
    if (stall_cnt !== 16'd5) begin n_fail++; $display("[TB] FAIL stall_five: got %0d expected 5", stall_cnt); end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_fail++; $display("[TB] FAIL stall_clear: got %0d expected 0", stall_cnt); end
    step();
    n_cmp++;
    if (stall_cnt !== 16'd1) begin n_fail++; $display("[TB] FAIL stall_resume: got %0d expected 1", stall_cnt); end
    out_ready = 1'b1;
    step();
    if (obs_out_xfer) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("[TB] FAIL stall_order: got %h expected nothing", obs_out_data);
      end else begin
        exp_beat = exp_q.pop_front();
        if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL stall_order: got %h expected %h", obs_out_data, exp_beat); end
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd1 || out_valid !== 1'b0) begin
      n_fail++; $display("[TB] FAIL stall_drain: got cnt=%0d v=%b expected cnt=1 v=0", stall_cnt, out_valid);
    end
  endtask

  task automatic test_saturate();
    sat_out_ready = 1'b0;
    sat_in_valid  = 1'b1;
    sat_in_data   = 8'h11;
    step();
    sat_in_valid = 1'b0;
    for (int c = 0; c < 7; c++) step();
    n_cmp++;
    if (sat_stall_cnt !== 3'd7) begin n_fail++; $display("[TB] FAIL sat_reach: got %0d expected 7", sat_stall_cnt); end
    for (int c = 0; c < 3; c++) step();
    n_cmp++;
    if (sat_stall_cnt !== 3'd7) begin n_fail++; $display("[TB] FAIL sat_hold: got %0d expected 7", sat_stall_cnt); end
    sat_clr_cnt = 1'b1;
    step();
    sat_clr_cnt   = 1'b0;
    sat_out_ready = 1'b1;
    n_cmp++;
    if (sat_stall_cnt !== 3'd0) begin n_fail++; $display("[TB] FAIL sat_clear: got %0d expected 0", sat_stall_cnt); end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h21;
    step();
    in_data = 8'h22;
    step();
    flush   = 1'b1;
    in_data = 8'h23;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL flush_state: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if (obs_out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_leak: got v=%b d=%h expected v=0", obs_out_valid, obs_out_data); end
    end
    in_valid = 1'b1;
    in_data  = 8'h30;
    step();
    in_valid = 1'b0;
    step();
    n_cmp++;
    if (!obs_out_xfer) begin
      n_fail++; $display("[TB] FAIL flush_recover: got no output expected 30");
    end else if (exp_q.size() == 0) begin
      n_fail++; $display("[TB] FAIL flush_recover: got %h expected nothing", obs_out_data);
    end else begin
      exp_beat = exp_q.pop_front();
      if (obs_out_data !== exp_beat) begin n_fail++; $display("[TB] FAIL flush_recover: got %h expected %h", obs_out_data, exp_beat); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'h77) begin
      n_fail++; $display("[TB] FAIL areset_setup: got v=%b d=%h expected v=1 d=77", out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL areset_clear: got v=%b d=%h rdy=%b expected v=0 d=00 rdy=1", out_valid, out_data, in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h99;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (!obs_in_xfer || out_valid !== 1'b1 || out_data !== 8'h99) begin
      n_fail++; $display("[TB] FAIL areset_first: got took=%b v=%b d=%h expected took=1 v=1 d=99", obs_in_xfer, out_valid, out_data);
    end
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    out_ready = 1'b0; clr_cnt = 1'b0;
    sat_flush = 1'b0; sat_in_valid = 1'b0; sat_in_data = 8'h00;
    sat_out_ready = 1'b0; sat_clr_cnt = 1'b0;
    obs_out_valid = 1'b0; obs_out_data = 8'h00; obs_out_xfer = 1'b0; obs_in_xfer = 1'b0;
    exp_beat = 8'h00;

    test_reset();
    test_stream();
    test_skid();
    test_back_to_back();
    test_stall();
    test_saturate();
    test_flush();
    test_async_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
